// File: rtl/alu_share_pkg.sv
// Shared constants for the add/sub ALU arbiter: opcode encodings and the
// response-port state encoding.
package alu_share_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ZERO = 2'b10;

    // Response register condition, decoded from rsp_valid/rsp_ready
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_core.sv
// Combinational add/sub datapath shared by all requesters.
// cy is bit DATA_W of the widened add/sub: carry on add, borrow on sub.
module alu_share_core
    import alu_share_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] res,
    output logic              cy
);

    logic [DATA_W:0] wide;

    // Widen by one bit so the top bit captures carry/borrow
    always_comb begin
        wide = '0;
        case (op)
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            OP_SUB:  wide = {1'b0, a} - {1'b0, b};
            OP_ZERO: wide = '0;
            default: wide = '0;
        endcase
        res = wide[DATA_W-1:0];
        cy  = wide[DATA_W];
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one registered add/sub ALU among NUM_REQ
// valid/ready requesters. One-entry response register tagged with the
// requester index; one-cycle latency, full throughput when rsp_ready=1.
// Optional: define ALU_SHARE_PERF_EN for saturating grant/stall counters.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [2*NUM_REQ-1:0]      req_op,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_cy
`ifdef ALU_SHARE_PERF_EN
    ,
    output logic [16*NUM_REQ-1:0]     perf_grants,
    output logic [15:0]               perf_stall
`endif
);

    // First valid requester at or after ptr, wrapping; MSB flags a hit
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    ptr);
        logic            f;
        logic [ID_W-1:0] s;
        int              p;
        f = 1'b0;
        s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            p = int'(ptr) + k;
            if (p >= NUM_REQ) p = p - NUM_REQ;
            if (!f && valid[p]) begin
                f = 1'b1;
                s = ID_W'(p);
            end
        end
        return {f, s};
    endfunction

    state_t              state;
    logic [ID_W-1:0]     rr_ptr, rr_ptr_d;
    logic                can_accept, found, xfer;
    logic [ID_W-1:0]     gnt;
    int                  gi;
    logic [1:0]          g_op;
    logic [DATA_W-1:0]   g_a, g_b, alu_res;
    logic                alu_cy;
    logic                rsp_valid_d, rsp_cy_d;
    logic [ID_W-1:0]     rsp_id_d;
    logic [DATA_W-1:0]   rsp_data_d;

    // Arbitration: pick a winner, drive one-hot ready, mux its operands.
    // Ready is held low in reset so nothing is accepted before the block is live.
    always_comb begin
        can_accept   = rst_n && (!rsp_valid || rsp_ready);
        {found, gnt} = rr_pick(req_valid, rr_ptr);
        xfer         = can_accept && found;
        gi           = int'(gnt);
        req_ready    = '0;
        if (xfer) req_ready[gi] = 1'b1;
        g_op = req_op[2*gi +: 2];
        g_a  = req_a[DATA_W*gi +: DATA_W];
        g_b  = req_b[DATA_W*gi +: DATA_W];
    end

    alu_share_core #(.DATA_W(DATA_W)) u_core (
        .op  (g_op),
        .a   (g_a),
        .b   (g_b),
        .res (alu_res),
        .cy  (alu_cy)
    );

    // Next state of the response register and round-robin pointer
    always_comb begin
        state = ST_IDLE;
        if (rsp_valid) state = rsp_ready ? ST_BUSY : ST_STALL;

        rsp_valid_d = rsp_valid;
        rsp_id_d    = rsp_id;
        rsp_data_d  = rsp_data;
        rsp_cy_d    = rsp_cy;
        rr_ptr_d    = rr_ptr;

        case (state)
            ST_IDLE, ST_BUSY: begin
                if (xfer) begin
                    // Reload in the same cycle the old result drains: no bubble
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = gnt;
                    rsp_data_d  = alu_res;
                    rsp_cy_d    = alu_cy;
                    rr_ptr_d    = (gi + 1 == NUM_REQ) ? '0 : ID_W'(gi + 1);
                end else begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: ; // STALL: hold everything
        endcase
    end

    // Response register and pointer; reset discards any pending result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_cy    <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            rsp_valid <= rsp_valid_d;
            rsp_id    <= rsp_id_d;
            rsp_data  <= rsp_data_d;
            rsp_cy    <= rsp_cy_d;
            rr_ptr    <= rr_ptr_d;
        end
    end

`ifdef ALU_SHARE_PERF_EN
    logic [NUM_REQ-1:0][15:0] grant_cnt;
    logic [15:0]              stall_cnt;

    assign perf_grants = grant_cnt;
    assign perf_stall  = stall_cnt;

    // Saturating per-requester transfer counters and stall-cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i] && grant_cnt[i] != 16'hFFFF)
                    grant_cnt[i] <= grant_cnt[i] + 16'd1;
            end
            if (state == ST_STALL && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one registered add/sub ALU datapath between NUM_REQ requesters.
- Each requester uses a valid/ready handshake.
- Arbitration is round-robin; one operation is accepted per cycle.
- The result is returned through a one-entry registered response port, tagged with the requester index.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, operand/result width.
- ID_W, 2, response tag width; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_op  input  2*NUM_REQ  packed opcodes; requester i at [2i+1:2i].
- req_a  input  DATA_W*NUM_REQ  packed operand A.
- req_b  input  DATA_W*NUM_REQ  packed operand B.
- rsp_valid  output  1  response holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  ID_W  index of the requester that issued the result.
- rsp_data  output  DATA_W  ALU result.
- rsp_cy  output  1  carry-out on add, borrow on sub, 0 otherwise.

Behaviour:
- Reset (async assert, sync deassert by the system): rsp_valid=0, rsp_id=0, rsp_data=0, rsp_cy=0, rr_ptr=0, state=IDLE. req_ready is 0 during reset.
- Opcodes:
  - 00: A+B, mod 2**DATA_W.
  - 01: A-B, mod 2**DATA_W.
  - 10/11: result 0, cy 0.
- Carry/borrow: cy is the bit DATA_W of the (DATA_W+1)-bit add/sub.
- Accept condition: can_accept = !rsp_valid || rsp_ready.
- Grant selection: when can_accept, grant the first requester with valid set, searching from rr_ptr upward with wrap-around. req_ready is combinational, one-hot on the granted index, and 0 when !can_accept.
- Transfer: occurs on req_valid[i] && req_ready[i] at edge T. rsp_valid/rsp_data/rsp_cy/rsp_id are updated at T+1, so latency is 1 cycle.
- Throughput: with rsp_ready held at 1, one result per cycle.
- Pointer update: after a transfer from index g, rr_ptr <= (g+1) mod NUM_REQ. With no transfer, rr_ptr holds.
- Response handshake: the response completes on rsp_valid && rsp_ready.
  - If a new transfer happens in the same cycle, the register reloads; rsp_valid stays 1 with no bubble.
  - If there is no new transfer, rsp_valid <= 0.
- Stall: while rsp_valid && !rsp_ready, rsp_data/rsp_id/rsp_cy are held stable and all req_ready are 0.
- States are derived from rsp_valid/rsp_ready:
  - IDLE (rsp_valid=0).
  - BUSY (rsp_valid=1, rsp_ready=1).
  - STALL (rsp_valid=1, rsp_ready=0).
- Transitions:
  - IDLE→BUSY/STALL on transfer.
  - BUSY→IDLE when there is no transfer.
  - STALL→BUSY on rsp_ready.
- Requester obligation: a requester holds valid/op/a/b stable until accepted. The block does not check this.
- No valid requests: req_ready all 0; the register drains normally.
- Reset mid-operation: the pending response is discarded with no output; the pointer returns to 0.
- Sequential logic uses non-blocking assignments only; combinational arbitration uses blocking assignments only; the two are never mixed in one always block.

Optional Feature:
- Macro ALU_SHARE_PERF_EN.
- When defined:
  - Adds output perf_grants (16*NUM_REQ): per-requester saturating 16-bit transfer counters.
  - Adds output perf_stall (16): a saturating count of STALL cycles.
  - Counters reset to 0 on rst_n and stick at 16'hFFFF.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package alu_share_pkg:
  - Opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_ZERO=2'b10.
  - State encoding ST_IDLE, ST_BUSY, ST_STALL.
- Sub-module alu_share_core: combinational op/a/b→result/cy using the opcode table above. It is instantiated once on the granted operands; the register stage stays in the top.
- Round-robin search stays in the top as a function.

Test Plan:
- Reset, then req0 valid with op=00, a=8'hF0, b=8'h20 → req_ready=0001 at T; at T+1 rsp_valid=1, rsp_data=8'h10, rsp_cy=1, rsp_id=0.
- Sub borrow: op=01, a=3, b=5 → rsp_data=8'hFE, rsp_cy=1. Op=10 with any operands → rsp_data=0, rsp_cy=0.
- All four requesters valid, rsp_ready=1 → grant order 0,1,2,3,0 on consecutive cycles; rsp_valid stays 1 with no bubbles.
- rsp_ready=0 for 3 cycles while holding a result → req_ready=0, outputs stable. Release → the held result is consumed and the next grant loads in the same cycle.
- rst_n pulsed low while rsp_valid=1 and in STALL → outputs immediately 0. After release, req2 alone valid → granted, rsp_id=2.
- ALU_SHARE_PERF_EN defined: 5 grants to req1 plus 3 stall cycles → perf_grants[1]=5, perf_stall=3; a forced count of 16'hFFFF stays at 16'hFFFF.
